// File: rtl/regpair_pkg.sv
// Shared codes and state encoding for the 8085 register-pair sequencer.
// Optional XCHG support is enabled by defining REGPAIR_XCHG_EN.
package regpair_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int REGBIT_DEF   = 3;
  localparam int CYBIT_DEF    = 0;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_A = 3'd7;

  localparam logic [1:0] OP_INX  = 2'b00;
  localparam logic [1:0] OP_DCX  = 2'b01;
  localparam logic [1:0] OP_DAD  = 2'b10;
  localparam logic [1:0] OP_XCHG = 2'b11;

  localparam logic [1:0] RP_BC  = 2'b00;
  localparam logic [1:0] RP_DE  = 2'b01;
  localparam logic [1:0] RP_HL  = 2'b10;
  localparam logic [1:0] RP_INV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDP  = 3'd1,
    ST_RDH  = 3'd2,
    ST_WRLO = 3'd3,
    ST_WRHI = 3'd4,
    ST_WRE  = 3'd5,
    ST_WRD  = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  // XCHG ignores rpair, so it is the only op that cannot be rejected for SP
  function automatic logic req_valid(input logic [1:0] op, input logic [1:0] rpair);
`ifdef REGPAIR_XCHG_EN
    if (op == OP_XCHG) begin
      return 1'b1;
    end else begin
      return rpair != RP_INV;
    end
`else
    return (op != OP_XCHG) && (rpair != RP_INV);
`endif
  endfunction

endpackage

// File: rtl/regpair_decode.sv
// Maps op/rpair to the register-file source and destination byte addresses.
// Honours REGPAIR_XCHG_EN for the D/E <-> H/L exchange.
module regpair_decode
  import regpair_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] rpair,
  output logic [2:0] src_hi,
  output logic [2:0] src_lo,
  output logic [2:0] dst_hi,
  output logic [2:0] dst_lo
);

  logic [2:0] pair_hi;
  logic [2:0] pair_lo;

  // pair code to high/low register codes
  always_comb begin
    pair_hi = 3'd0;
    pair_lo = 3'd0;
    case (rpair)
      RP_BC: begin pair_hi = REG_B; pair_lo = REG_C; end
      RP_DE: begin pair_hi = REG_D; pair_lo = REG_E; end
      RP_HL: begin pair_hi = REG_H; pair_lo = REG_L; end
      default: begin pair_hi = 3'd0; pair_lo = 3'd0; end
    endcase
  end

  // DAD (and XCHG) always land the result in HL
  always_comb begin
    src_hi = pair_hi;
    src_lo = pair_lo;
    dst_hi = pair_hi;
    dst_lo = pair_lo;
    case (op)
      OP_DAD: begin
        dst_hi = REG_H;
        dst_lo = REG_L;
      end
`ifdef REGPAIR_XCHG_EN
      OP_XCHG: begin
        src_hi = REG_D;
        src_lo = REG_E;
        dst_hi = REG_H;
        dst_lo = REG_L;
      end
`endif
      default: begin
        dst_hi = pair_hi;
        dst_lo = pair_lo;
      end
    endcase
  end

endmodule

// File: rtl/regpair_seq.sv
// Multi-cycle INX/DCX/DAD sequencer driving the 8085 register file ports.
// Define REGPAIR_XCHG_EN to add XCHG (op=11) as a four-write exchange.
module regpair_seq
  import regpair_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int REGBIT   = REGBIT_DEF,
  parameter int CYBIT    = CYBIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [1:0]          rpair,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rf_r1enb,
  output logic                rf_r2enb,
  output logic [REGBIT-1:0]   rf_r1add,
  output logic [REGBIT-1:0]   rf_r2add,
  input  logic [DATASIZE-1:0] rf_r1dat,
  input  logic [DATASIZE-1:0] rf_r2dat,
  output logic                rf_wrenb,
  output logic [REGBIT-1:0]   rf_waddr,
  output logic [DATASIZE-1:0] rf_wdata,
  output logic                rf_flenb,
  output logic [DATASIZE-1:0] rf_ifdat,
  input  logic [DATASIZE-1:0] rf_ofdat
);

  localparam int RW = 2 * DATASIZE;

  state_e state_q, state_d;
  logic [1:0] op_q, op_d, rp_q, rp_d;
  logic [RW-1:0] opnd_q, opnd_d, hl_q, hl_d, res_q, res_d;
  logic [RW:0] calc;
  logic cy_q, cy_d;
  logic [DATASIZE-1:0] flg_q, flg_d, fl_new;

  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic rf_r1enb_q, rf_r1enb_d, rf_r2enb_q, rf_r2enb_d;
  logic [REGBIT-1:0] rf_r1add_q, rf_r1add_d, rf_r2add_q, rf_r2add_d;
  logic rf_wrenb_q, rf_wrenb_d, rf_flenb_q, rf_flenb_d;
  logic [REGBIT-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATASIZE-1:0] rf_wdata_q, rf_wdata_d, rf_ifdat_q, rf_ifdat_d;
  logic [2:0] src_hi, src_lo, dst_hi, dst_lo;

  // Decode looks at the next-cycle op/rpair so registered addresses line up with the state
  regpair_decode u_decode (
    .op     (op_d),
    .rpair  (rp_d),
    .src_hi (src_hi),
    .src_lo (src_lo),
    .dst_hi (dst_hi),
    .dst_lo (dst_lo)
  );

  // next state, request latch and rejection pulse
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rp_d    = rp_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (req_valid(op, rpair)) begin
            op_d    = op;
            rp_d    = rpair;
            state_d = ST_RDP;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDP: begin
        if ((op_q == OP_INX) || (op_q == OP_DCX)) begin
          state_d = ST_WRLO;
        end else begin
          state_d = ST_RDH;
        end
      end
      ST_RDH:  state_d = ST_WRLO;
      ST_WRLO: state_d = ST_WRHI;
      ST_WRHI: begin
`ifdef REGPAIR_XCHG_EN
        if (op_q == OP_XCHG) begin
          state_d = ST_WRE;
        end else begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_DONE;
`endif
      end
      ST_WRE:  state_d = ST_WRD;
      ST_WRD:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture and 17-bit arithmetic; the result is formed from the
  // just-read data so WRLO can drive it on the very next cycle
  always_comb begin
    if (state_q == ST_RDP) begin
      opnd_d = {rf_r1dat, rf_r2dat};
    end else begin
      opnd_d = opnd_q;
    end
    if (state_q == ST_RDH) begin
      hl_d  = {rf_r1dat, rf_r2dat};
      flg_d = rf_ofdat;
    end else begin
      hl_d  = hl_q;
      flg_d = flg_q;
    end
    case (op_d)
      OP_INX:  calc = {1'b0, opnd_d + RW'(1)};
      OP_DCX:  calc = {1'b0, opnd_d - RW'(1)};
      OP_DAD:  calc = {1'b0, hl_d} + {1'b0, opnd_d};
      default: calc = {1'b0, opnd_d};
    endcase
    if ((state_q == ST_RDP) || (state_q == ST_RDH)) begin
      res_d = calc[RW-1:0];
      cy_d  = calc[RW];
    end else begin
      res_d = res_q;
      cy_d  = cy_q;
    end
  end

  // register-file port values for the state being entered
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    rf_r1enb_d = 1'b0;
    rf_r2enb_d = 1'b0;
    rf_r1add_d = '0;
    rf_r2add_d = '0;
    rf_wrenb_d = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    rf_flenb_d = 1'b0;
    rf_ifdat_d = '0;
    fl_new     = flg_d;
    fl_new[CYBIT] = cy_d;
    case (state_d)
      ST_RDP: begin
        rf_r1enb_d = 1'b1;
        rf_r2enb_d = 1'b1;
        rf_r1add_d = REGBIT'(src_hi);
        rf_r2add_d = REGBIT'(src_lo);
      end
      ST_RDH: begin
        rf_r1enb_d = 1'b1;
        rf_r2enb_d = 1'b1;
        rf_r1add_d = REGBIT'(REG_H);
        rf_r2add_d = REGBIT'(REG_L);
      end
      ST_WRLO: begin
        rf_wrenb_d = 1'b1;
        rf_waddr_d = REGBIT'(dst_lo);
        rf_wdata_d = res_d[DATASIZE-1:0];
      end
      ST_WRHI: begin
        rf_wrenb_d = 1'b1;
        rf_waddr_d = REGBIT'(dst_hi);
        rf_wdata_d = res_d[RW-1:DATASIZE];
        if (op_d == OP_DAD) begin
          rf_flenb_d = 1'b1;
          rf_ifdat_d = fl_new;
        end else begin
          rf_flenb_d = 1'b0;
        end
      end
      ST_WRE: begin
        rf_wrenb_d = 1'b1;
        rf_waddr_d = REGBIT'(REG_E);
        rf_wdata_d = hl_d[DATASIZE-1:0];
      end
      ST_WRD: begin
        rf_wrenb_d = 1'b1;
        rf_waddr_d = REGBIT'(REG_D);
        rf_wdata_d = hl_d[RW-1:DATASIZE];
      end
      default: begin
        rf_wrenb_d = 1'b0;
      end
    endcase
  end

  // all state and registered outputs; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rp_q       <= '0;
      opnd_q     <= '0;
      hl_q       <= '0;
      res_q      <= '0;
      cy_q       <= 1'b0;
      flg_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rf_r1enb_q <= 1'b0;
      rf_r2enb_q <= 1'b0;
      rf_r1add_q <= '0;
      rf_r2add_q <= '0;
      rf_wrenb_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_flenb_q <= 1'b0;
      rf_ifdat_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rp_q       <= rp_d;
      opnd_q     <= opnd_d;
      hl_q       <= hl_d;
      res_q      <= res_d;
      cy_q       <= cy_d;
      flg_q      <= flg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rf_r1enb_q <= rf_r1enb_d;
      rf_r2enb_q <= rf_r2enb_d;
      rf_r1add_q <= rf_r1add_d;
      rf_r2add_q <= rf_r2add_d;
      rf_wrenb_q <= rf_wrenb_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_flenb_q <= rf_flenb_d;
      rf_ifdat_q <= rf_ifdat_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rf_r1enb = rf_r1enb_q;
  assign rf_r2enb = rf_r2enb_q;
  assign rf_r1add = rf_r1add_q;
  assign rf_r2add = rf_r2add_q;
  assign rf_wrenb = rf_wrenb_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_flenb = rf_flenb_q;
  assign rf_ifdat = rf_ifdat_q;

endmodule

// File: tb/tb_regpair_seq.sv
// Table-driven bench for regpair_seq with a behavioural register file.
// Covers REGPAIR_XCHG_EN when the macro is defined for the build.
module tb_regpair_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op, rpair;
  logic        busy, done, err;
  logic        rf_r1enb, rf_r2enb, rf_wrenb, rf_flenb;
  logic [2:0]  rf_r1add, rf_r2add, rf_waddr;
  logic [7:0]  rf_r1dat, rf_r2dat, rf_wdata, rf_ifdat, rf_ofdat;

  logic [7:0]  regs [0:7];
  logic [7:0]  flags_r;
  logic        ld_en;
  logic [47:0] ld_regs;
  logic [7:0]  ld_flags;
  int          wr_cnt, fl_cnt;
  int          n_vec, n_mis, n_chk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  rp;
    logic [47:0] r_in;   // {B,C,D,E,H,L}
    logic [7:0]  f_in;
    logic [47:0] r_exp;
    logic [7:0]  f_exp;
    int          done_c;
    int          err_c;
    int          n_wr;
    int          n_fl;
  } vec_t;

  vec_t vt [12];

  regpair_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rpair(rpair),
    .busy(busy), .done(done), .err(err),
    .rf_r1enb(rf_r1enb), .rf_r2enb(rf_r2enb),
    .rf_r1add(rf_r1add), .rf_r2add(rf_r2add),
    .rf_r1dat(rf_r1dat), .rf_r2dat(rf_r2dat),
    .rf_wrenb(rf_wrenb), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_flenb(rf_flenb), .rf_ifdat(rf_ifdat), .rf_ofdat(rf_ofdat)
  );

  always #5 clk = ~clk;

  assign rf_r1dat = regs[rf_r1add];
  assign rf_r2dat = regs[rf_r2add];
  assign rf_ofdat = flags_r;

  // register file with a bench-side preload path
  always @(posedge clk) begin
    if (ld_en) begin
      regs[0] <= ld_regs[47:40];
      regs[1] <= ld_regs[39:32];
      regs[2] <= ld_regs[31:24];
      regs[3] <= ld_regs[23:16];
      regs[4] <= ld_regs[15:8];
      regs[5] <= ld_regs[7:0];
      regs[6] <= 8'h00;
      regs[7] <= 8'h00;
      flags_r <= ld_flags;
      wr_cnt  <= 0;
      fl_cnt  <= 0;
    end else begin
      if (rf_wrenb) begin
        regs[rf_waddr] <= rf_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (rf_flenb) begin
        flags_r <= rf_ifdat;
        fl_cnt <= fl_cnt + 1;
      end
    end
  end

  function automatic logic [47:0] pack_regs();
    return {regs[0], regs[1], regs[2], regs[3], regs[4], regs[5]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [47:0] r, input logic [7:0] f);
    @(negedge clk);
    ld_regs  = r;
    ld_flags = f;
    ld_en    = 1'b1;
    @(negedge clk);
    ld_en    = 1'b0;
  endtask

  // start one operation, watch 15 cycles; cycle 1 is the one after the start edge
  task automatic run_op(input logic [1:0] o, input logic [1:0] r,
                        output int dc, output int ec, output int nd);
    dc = 0; ec = 0; nd = 0;
    @(negedge clk);
    op = o; rpair = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (dc == 0) dc = k;
      end
      if (err && (ec == 0)) ec = k;
    end
  endtask

  initial begin
    int dc, ec, nd, d1, d2, b1, b6;
    rst = 1'b1; start = 1'b0; op = 2'b00; rpair = 2'b00;
    ld_en = 1'b0; ld_regs = 48'h0; ld_flags = 8'h00;
    n_vec = 0; n_mis = 0; n_chk = 0;

    //           op     rp     r_in              f_in   r_exp             f_exp  done err wr fl
    vt[0]  = '{2'b00, 2'b00, 48'h12FF00000000, 8'h02, 48'h130000000000, 8'h02, 4, 0, 2, 0};
    vt[1]  = '{2'b01, 2'b01, 48'h112200003344, 8'h02, 48'h1122FFFF3344, 8'h02, 4, 0, 2, 0};
    vt[2]  = '{2'b10, 2'b00, 48'h800000008001, 8'h02, 48'h800000000001, 8'h03, 5, 0, 2, 1};
    vt[3]  = '{2'b10, 2'b10, 48'h000000001234, 8'h03, 48'h000000002468, 8'h02, 5, 0, 2, 1};
    vt[4]  = '{2'b00, 2'b10, 48'h00000000FFFF, 8'h01, 48'h000000000000, 8'h01, 4, 0, 2, 0};
    vt[5]  = '{2'b01, 2'b10, 48'h000000000100, 8'h00, 48'h0000000000FF, 8'h00, 4, 0, 2, 0};
    vt[6]  = '{2'b00, 2'b01, 48'h000000FF0000, 8'h00, 48'h000001000000, 8'h00, 4, 0, 2, 0};
    vt[7]  = '{2'b00, 2'b11, 48'h123456789ABC, 8'h55, 48'h123456789ABC, 8'h55, 0, 1, 0, 0};
`ifdef REGPAIR_XCHG_EN
    vt[8]  = '{2'b11, 2'b11, 48'h0000AABB1122, 8'h02, 48'h00001122AABB, 8'h02, 7, 0, 4, 0};
`else
    vt[8]  = '{2'b11, 2'b00, 48'h0000AABB1122, 8'h02, 48'h0000AABB1122, 8'h02, 0, 1, 0, 0};
`endif
    vt[9]  = '{2'b10, 2'b01, 48'h0000FFFF0001, 8'hFE, 48'h0000FFFF0000, 8'hFF, 5, 0, 2, 1};
    vt[10] = '{2'b10, 2'b00, 48'h00FF00000001, 8'h01, 48'h00FF00000100, 8'h00, 5, 0, 2, 1};
    vt[11] = '{2'b10, 2'b11, 48'h010203040506, 8'h00, 48'h010203040506, 8'h00, 0, 1, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    check("reset_outputs",
          {32'h0, busy, done, err, rf_r1enb, rf_r2enb, rf_r1add, rf_r2add,
           rf_wrenb, rf_waddr, rf_wdata, rf_flenb, rf_ifdat}, 64'h0);
    rst = 1'b0;

    foreach (vt[i]) begin
      load(vt[i].r_in, vt[i].f_in);
      run_op(vt[i].op, vt[i].rp, dc, ec, nd);
      n_vec++;
      check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vt[i].done_c));
      check($sformatf("v%0d_err_cycle", i), 64'(ec), 64'(vt[i].err_c));
      check($sformatf("v%0d_done_count", i), 64'(nd), 64'((vt[i].done_c != 0) ? 1 : 0));
      check($sformatf("v%0d_regs", i), 64'(pack_regs()), 64'(vt[i].r_exp));
      check($sformatf("v%0d_flags", i), 64'(flags_r), 64'(vt[i].f_exp));
      check($sformatf("v%0d_writes", i), 64'(wr_cnt), 64'(vt[i].n_wr));
      check($sformatf("v%0d_flag_writes", i), 64'(fl_cnt), 64'(vt[i].n_fl));
    end

    // DAD HL with starts during RDH and DONE (ignored), then one in IDLE (accepted)
    load(48'h000000001234, 8'h03);
    d1 = 0; d2 = 0; nd = 0; b1 = 0; b6 = 1;
    @(negedge clk);
    op = 2'b10; rpair = 2'b10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) b1 = int'(busy);
      if (k == 6) b6 = int'(busy);
      if (done) begin
        nd++;
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
      op = 2'b00; rpair = 2'b00;
      start = (k == 2) || (k == 5) || (k == 6);
    end
    n_vec++;
    check("seq_busy_cycle1", 64'(b1), 64'd1);
    check("seq_busy_idle_after_done", 64'(b6), 64'd0);
    check("seq_done_count", 64'(nd), 64'd2);
    check("seq_first_done", 64'(d1), 64'd5);
    check("seq_second_done", 64'(d2), 64'd10);
    check("seq_regs", 64'(pack_regs()), 64'h000100002468);
    check("seq_flags", 64'(flags_r), 64'h02);

    // reset while in WRLO: the low write stands, nothing else follows
    load(48'h12FF00000000, 8'h00);
    nd = 0;
    @(negedge clk);
    op = 2'b00; rpair = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wrlo_wrenb", 64'(rf_wrenb), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_wrlo_outputs",
          {32'h0, busy, done, err, rf_r1enb, rf_r2enb, rf_r1add, rf_r2add,
           rf_wrenb, rf_waddr, rf_wdata, rf_flenb, rf_ifdat}, 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || rf_wrenb) nd++;
    end
    n_vec++;
    check("rst_no_done_or_write", 64'(nd), 64'd0);
    check("rst_partial_regs", 64'(pack_regs()), 64'h120000000000);
    check("rst_write_count", 64'(wr_cnt), 64'd1);

    run_op(2'b00, 2'b00, dc, ec, nd);
    n_vec++;
    check("post_rst_done", 64'(dc), 64'd4);
    check("post_rst_regs", 64'(pack_regs()), 64'h120100000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/regpair_seq.md
Name: regpair_seq

Overview:
- Multi-cycle sequencer for 16-bit register-pair operations in the 8085 core: INX, DCX, DAD.
- Sits between the decoder and the 8-bit register file.
- Drives the register file's two read ports, single write port and flag port.
- Reads pair halves, computes the 16-bit result, then writes the low and high bytes back on consecutive cycles.

Parameters:
DATASIZE, 8, register width; result width is 2*DATASIZE
REGBIT, 3, register-file address width
CYBIT, 0, bit index of the carry flag within the flag register

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
start  input  1  begin operation; sampled in IDLE only
op  input  2  00 INX, 01 DCX, 10 DAD, 11 reserved
rpair  input  2  00 BC, 01 DE, 10 HL, 11 invalid (SP is not in the register file)
busy  output  1  high from the cycle after accepted start until DONE inclusive
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse on rejected start
rf_r1enb  output  1  register-file read port 1 enable
rf_r2enb  output  1  register-file read port 2 enable
rf_r1add  output  REGBIT  read port 1 address (high byte)
rf_r2add  output  REGBIT  read port 2 address (low byte)
rf_r1dat  input  DATASIZE  read port 1 data
rf_r2dat  input  DATASIZE  read port 2 data
rf_wrenb  output  1  register-file write enable
rf_waddr  output  REGBIT  write address
rf_wdata  output  DATASIZE  write data
rf_flenb  output  1  flag write enable
rf_ifdat  output  DATASIZE  flag write data
rf_ofdat  input  DATASIZE  current flag register

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- On reset:
  - state IDLE.
  - busy, done, err, all enables = 0.
  - addresses = 0; rf_wdata and rf_ifdat = 0.
- Register codes: B0 C1 D2 E3 H4 L5 A7. Pair hi/lo: BC 0/1, DE 2/3, HL 4/5.
- Read-port timing: a port is read by presenting its address with its enable high for one cycle; data is registered internally on that clock edge.
- IDLE:
  - start=1 with op=11, or rpair=11 → err pulse next cycle; no register access; stay IDLE.
  - Otherwise latch op/rpair and go to RDP.
  - start while not IDLE is ignored.
- RDP:
  - r1add=pair hi, r2add=pair lo, both enables high; capture the 16-bit operand.
  - Next state is RDH for DAD, else WRLO.
- RDH (DAD only): r1add=H, r2add=L; capture HL; also capture rf_ofdat; go to WRLO.
- Compute, modulo 2^16:
  - INX: operand+1.
  - DCX: operand-1.
  - DAD: HL+operand; carry-out = bit 16 of the 17-bit sum.
- WRLO: write low result byte to the destination lo register (pair lo for INX/DCX, L for DAD); go to WRHI.
- WRHI:
  - Write the high byte to pair hi or H.
  - DAD also asserts rf_flenb with rf_ifdat = captured flags with bit CYBIT replaced by the carry; all other flag bits unchanged.
  - INX/DCX never touch flags.
- DONE: done=1 for one cycle; return to IDLE. A start is accepted on the cycle after DONE.
- Latency from start edge to done high:
  - INX/DCX: 4 cycles.
  - DAD: 5 cycles.
- Wrap-around: FFFF+1=0000; 0000-1=FFFF; no flag effect.
- DAD HL: operand and HL read the same registers; result is 2*HL.
- Enables are high only in their own state; never two writes in one cycle.
- Reset mid-operation: next cycle is IDLE with all enables low. Partial writes already done stand; no done pulse.

Optional Feature:
- Macro: REGPAIR_XCHG_EN.
- Defined:
  - op=11 is XCHG; rpair is ignored; never errors.
  - Sequence: RDP reads D/E, RDH reads H/L, then four write states: L←E, H←D, E←old L, D←old H.
  - Flags untouched; done 7 cycles after start.
- Undefined: op=11 gives an err pulse, as above.

Decomposition:
- Package regpair_pkg holds:
  - register codes, pair codes, op codes;
  - state encoding (IDLE, RDP, RDH, WRLO, WRHI, [WRE, WRD], DONE);
  - CYBIT default.
- Sub-module regpair_decode: combinational rpair/op → hi/lo source and destination addresses, used by the FSM.

Test Plan:
- B=12, C=FF, INX BC → writes C=00 then B=13; done at +4 cycles; flags unchanged.
- D=00, E=00, DCX DE → D=FF, E=FF; flag register unchanged (e.g. stays 0x02).
- H=80, L=01, B=80, C=00, flags=0x02, DAD BC → HL=0001, flags=0x03; done at +5 cycles.
- H=12, L=34, DAD HL → HL=2468, CY cleared (flags 0x03 → 0x02). Start pulsed during busy → ignored, single done.
- Reject cases:
  - rpair=11 → err pulse, no rf_wrenb seen.
  - op=11 without macro → err pulse.
  - With REGPAIR_XCHG_EN: D=AA, E=BB, H=11, L=22 → D=11, E=22, H=AA, L=BB.
- Reset asserted in WRLO → IDLE next cycle, no done, no further writes. A fresh INX afterwards completes normally.
